// File: rtl/accel_match_engine.sv
// rtl/accel_match_engine.sv - word-search accelerator: scans a memory range over OBI for a key
module accel_match_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      key_i,
    output logic             req_o,
    output logic [31:0]      addr_o,
    output logic             we_o,
    output logic [3:0]       be_o,
    output logic [31:0]      wdata_o,
    input  logic             gnt_i,
    input  logic             rvalid_i,
    input  logic [31:0]      rdata_i,
    input  logic             err_i,
    output logic             done_o,
    output logic             match_o,
    output logic             err_o
);

    // S_LOAD spends one cycle after the start edge so requests and the
    // zero-length done both appear from latched operands, not live inputs.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic [31:0]      base_q, base_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      key_q, key_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic             done_q, done_d;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic             start_edge;
    logic [LEN_W-1:0] idx_inc;

    assign start_edge = start_i & ~start_q;
    assign idx_inc    = idx_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        start_d = start_i;
        base_d  = base_q;
        len_d   = len_q;
        key_d   = key_q;
        idx_d   = idx_q;
        req_d   = req_q;
        addr_d  = addr_q;
        done_d  = done_q;
        match_d = match_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    base_d  = {base_addr_i[31:2], 2'b00};
                    len_d   = len_i;
                    key_d   = key_i;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    match_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (len_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = base_q;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (gnt_i) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rvalid_i) begin
                    if (err_i) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        match_d = 1'b0;
                        state_d = S_DONE;
                    end else if (rdata_i == key_q) begin
                        done_d  = 1'b1;
                        match_d = 1'b1;
                        state_d = S_DONE;
                    end else if (idx_q == len_q - LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // Address arithmetic wraps modulo 2^32 by construction.
                        idx_d   = idx_inc;
                        addr_d  = base_q + (32'(idx_inc) << 2);
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            key_q   <= '0;
            idx_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            base_q  <= base_d;
            len_q   <= len_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    assign req_o   = req_q;
    assign addr_o  = addr_q;
    assign we_o    = 1'b0;
    assign be_o    = 4'hF;
    assign wdata_o = '0;
    assign done_o  = done_q;
    assign match_o = match_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_accel_match_engine.sv
// tb/tb_accel_match_engine.sv - scoreboard bench for accel_match_engine
module tb_accel_match_engine;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic [31:0]      base_addr_i;
    logic [LEN_W-1:0] len_i;
    logic [31:0]      key_i;
    logic             req_o;
    logic [31:0]      addr_o;
    logic             we_o;
    logic [3:0]       be_o;
    logic [31:0]      wdata_o;
    logic             gnt_i;
    logic             rvalid_i;
    logic [31:0]      rdata_i;
    logic             err_i;
    logic             done_o;
    logic             match_o;
    logic             err_o;

    accel_match_engine #(.LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .key_i(key_i),
        .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
        .done_o(done_o), .match_o(match_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_addr_q [$];
    logic [1:0]  exp_res_q [$];
    int          gnt_delay  = 0;
    int          resp_delay = 0;
    bit          err_en     = 1'b0;
    logic [31:0] err_addr   = 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'h5A5A};
    endfunction

    // OBI memory: optional grant stall, optional response delay, error injection.
    initial begin
        logic [31:0] ga, sa;
        bit pend;
        int rc, sc;
        ga = '0; sa = '0; pend = 1'b0; rc = 0; sc = 0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
        forever begin
            @(negedge clk);
            gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
            if (pend) begin
                if (rc == 0) begin
                    rvalid_i = 1'b1;
                    rdata_i  = mem_rd(ga);
                    err_i    = err_en && (ga == err_addr);
                    pend     = 1'b0;
                end else begin
                    rc--;
                end
            end
            if (req_o) begin
                if (sc == 0) sa = addr_o;
                else check("stall_addr", addr_o, sa);
                if (sc < gnt_delay) begin
                    sc++;
                end else begin
                    gnt_i = 1'b1; sc = 0; ga = addr_o; pend = 1'b1; rc = resp_delay;
                    if (exp_addr_q.size() == 0) check("extra_req", 32'd1, 32'd0);
                    else check("req_addr", addr_o, exp_addr_q.pop_front());
                end
            end
        end
    end

    task automatic run_scan(input logic [31:0] base, input logic [LEN_W-1:0] len,
                            input logic [31:0] key, input bit toggle, output int lat);
        logic m, e;
        logic [31:0] a;
        logic [1:0] r;
        int cyc;
        m = 1'b0; e = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            a = (base & ~32'h3) + 32'(i) * 32'd4;
            exp_addr_q.push_back(a);
            if (err_en && a == err_addr) begin e = 1'b1; break; end
            if (mem_rd(a) == key) begin m = 1'b1; break; end
        end
        exp_res_q.push_back({m, e});
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        base_addr_i = base; len_i = len; key_i = key; start_i = 1'b1;
        @(negedge clk);
        check("done_clr", 32'(done_o), 32'd0);
        base_addr_i = 32'h5555_0000; len_i = '1; key_i = ~key;
        cyc = 0;
        while (!done_o && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (toggle && cyc == 3) start_i = 1'b0;
            if (toggle && cyc == 4) start_i = 1'b1;
        end
        lat = cyc;
        check("done", 32'(done_o), 32'd1);
        r = exp_res_q.pop_front();
        check("match", 32'(match_o), 32'(r[1]));
        check("err", 32'(err_o), 32'(r[0]));
        check("req_count", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, cyc;
        rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0; key_i = '0;
        for (int i = 0; i < 8; i++) mem[32'h1000 + 32'(i) * 4] = 32'h100 + 32'(i);
        repeat (3) @(negedge clk);
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_addr", addr_o, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_match", 32'(match_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("const_we_be_wdata", {we_o, be_o, wdata_o[26:0]}, {1'b0, 4'hF, 27'd0});
        rst_ni = 1'b1;

        run_scan(32'h1000, 16'd8, 32'h105, 1'b0, lat);
        check("lat_mid_match", 32'(lat), 32'd13);

        run_scan(32'h1000, 16'd8, 32'hDEAD, 1'b0, lat);
        check("lat_no_match", 32'(lat), 32'd17);

        run_scan(32'h1003, 16'd8, 32'h100, 1'b0, lat);
        check("lat_first_word", 32'(lat), 32'd3);

        run_scan(32'h1000, 16'd0, 32'h100, 1'b0, lat);
        check("lat_zero_len", 32'(lat), 32'd1);

        gnt_delay = 3; err_en = 1'b1; err_addr = 32'h1008;
        run_scan(32'h1000, 16'd8, 32'hDEAD, 1'b0, lat);
        repeat (4) begin
            @(negedge clk);
            check("err_no_req", 32'(req_o), 32'd0);
        end
        gnt_delay = 0; err_en = 1'b0;

        run_scan(32'h1000, 16'd8, 32'h102, 1'b0, lat);
        repeat (5) begin
            @(negedge clk);
            check("held_start_done", 32'(done_o), 32'd1);
            check("held_start_req", 32'(req_o), 32'd0);
        end

        resp_delay = 3;
        run_scan(32'h1000, 16'd4, 32'h101, 1'b1, lat);
        repeat (4) begin
            @(negedge clk);
            check("wait_toggle_done", 32'(done_o), 32'd1);
        end
        resp_delay = 0;

        resp_delay = 3;
        exp_addr_q.push_back(32'h1000);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        base_addr_i = 32'h1000; len_i = 16'd8; key_i = 32'h100; start_i = 1'b1;
        cyc = 0;
        while (!req_o && cyc < 50) begin @(negedge clk); cyc++; end
        while (req_o && cyc < 50) begin @(negedge clk); cyc++; end
        check("rst_reach_wait", 32'(cyc < 50), 32'd1);
        rst_ni = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("midrst_outs", {31'd0, req_o | done_o | match_o | err_o}, 32'd0);
        check("midrst_addr", addr_o, 32'd0);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk);
        check("late_rvalid_done", 32'(done_o), 32'd0);
        check("late_rvalid_match", 32'(match_o), 32'd0);
        check("midrst_req_count", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        resp_delay = 0;

        run_scan(32'hFFFF_FFF8, 16'd4, 32'hDEAD, 1'b0, lat);
        check("lat_wrap", 32'(lat), 32'd9);

        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/accel_match_engine.md
# accel_match_engine

Word-search accelerator that sits directly behind the MMIO control register block. It consumes that block's `start` level and produces the `done` and `match` status it reads back. On a rising edge of `start`, it fetches `len_i` consecutive 32-bit words from memory through an OBI manager port and compares each word against `key_i`. It stops at the first equal word or at the end of the range, then holds `done_o` and `match_o` until the next start.

## Interface
- `LEN_W`, default 16: width of the word-count input.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, active-low. One clock; reset is synchronous and active-low.
- `start_i`  in  1  start level from the MMIO block; only its 0→1 edge has effect.
- `base_addr_i`  in  32  byte address of the first word; bits [1:0] are ignored and treated as 0.
- `len_i`  in  LEN_W  number of words to scan.
- `key_i`  in  32  value to search for.
- `req_o`  out  1  OBI request.
- `addr_o`  out  32  OBI word-aligned address.
- `we_o`  out  1  always 0.
- `be_o`  out  4  always 4'hF.
- `wdata_o`  out  32  always 0.
- `gnt_i`  in  1  OBI grant.
- `rvalid_i`  in  1  OBI response valid.
- `rdata_i`  in  32  OBI read data.
- `err_i`  in  1  OBI response error.
- `done_o`  out  1  scan finished; held high.
- `match_o`  out  1  a matching word was found; valid while `done_o` is high.
- `err_o`  out  1  the scan was aborted by a bus error; valid while `done_o` is high.

## Operation
- **Start detection.** A registered copy `start_q` of `start_i` is kept. A start edge is `start_i & ~start_q`.
- **IDLE.**
  - On a start edge, latch `base_addr_i & ~3`, `len_i` and `key_i`, clear `idx`, and clear `done_o`, `match_o` and `err_o`.
  - If the latched `len_i` is 0, go to DONE with match=0 and err=0. Otherwise go to REQ.
- **REQ.**
  - `req_o`=1 and `addr_o` = base + (idx<<2). The address is 32-bit with modulo-2^32 wrap.
  - `addr_o` stays stable until `gnt_i`.
  - On `gnt_i`, go to WAIT.
- **WAIT.**
  - `req_o`=0, so at most one transaction is outstanding.
  - On `rvalid_i` with `err_i`=1, go to DONE with err=1 and match=0.
  - On `rvalid_i` with `rdata_i`==key, go to DONE with match=1.
  - On `rvalid_i` with no error and no match:
    - If idx == len-1, go to DONE with match=0.
    - Otherwise, idx++ and go to REQ.
- **DONE.** `done_o`=1. `match_o` and `err_o` hold their final values. A start edge behaves as it does in IDLE, so the block restarts directly.
- **Start edges while busy.** A start edge in REQ or WAIT is ignored, because `start_q` still tracks `start_i`. Software must drop `start` and raise it again after `done_o` to re-run.
- **Input changes mid-scan.** Changes to `base_addr_i`, `len_i` or `key_i` during a scan have no effect.
- **`idx` width.** `idx` is LEN_W bits. `len_i` = 2^LEN_W−1 is the maximum and scans all words without overflow.

## Timing
- **Reset.** Reset is synchronous. While `rst_ni`=0 at a clock edge:
  - state goes to IDLE;
  - `start_q`=0 and idx=0;
  - `req_o`=0, `addr_o`=0, `done_o`=0, `match_o`=0, `err_o`=0.
- **Mid-scan reset.** Reset during a scan drops `req_o` on the next edge. Any response arriving after that is ignored.
- **Registered outputs.** `req_o`, `addr_o`, `done_o`, `match_o` and `err_o` are registered. `we_o`, `be_o` and `wdata_o` are constants.
- **Start to first request.** For a start edge sampled at edge N, `req_o`=1 after edge N+1.
- **Per-word cost with zero wait states** (grant in the request's first cycle, `rvalid_i` in the next cycle): 2 cycles per word.
- **First-word match latency.** With a match on word 0 and zero wait states, `done_o`=1 after edge N+3.
- **Grant.** `gnt_i` is sampled only in REQ.
- **Response.** `rvalid_i` is sampled only in WAIT. A `rvalid_i` in any other state is ignored.
- **Zero-length scan.** With `len_i`=0, `done_o`=1 after edge N+1 and no bus request is issued.

## Test plan
- **Match mid-range.** Memory holds words 0..7 = 0x100+i, with `key_i`=0x105, `len_i`=8 and base 0x1000. Expected:
  - requests go to 0x1000..0x1014 only;
  - `done_o`=1, `match_o`=1, `err_o`=0.
- **No match.** Same memory with `key_i`=0xDEAD. Expected:
  - 8 requests, the last at 0x101C;
  - `done_o`=1, `match_o`=0.
- **Zero length.** `len_i`=0. Expected: no `req_o`, and `done_o`=1 one cycle after the start edge with `match_o`=0.
- **Stalls and bus error.**
  - `gnt_i` is delayed by 3 cycles. Expected: `addr_o` is stable throughout the stall.
  - `err_i`=1 on word 2. Expected: `done_o`=1, `err_o`=1, `match_o`=0, with no further requests.
- **Start handling.**
  - `start_i` is held high across done. Expected: no restart.
  - `start_i` toggles 0→1 while in WAIT. Expected: ignored.
  - `start_i` toggles 0→1 after done. Expected: `done_o` clears and a new scan starts.
- **Reset mid-scan and address wrap.**
  - `rst_ni`=0 while in WAIT. Expected: all outputs are 0 at the next edge, and a late `rvalid_i` is ignored.
  - Base 0xFFFF_FFF8 with `len_i`=4. Expected: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
